// File: rtl/uart_pkg.sv
// Shared UART transmitter types and frame constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_IDX_W  = 3;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } tx_state_e;

endpackage

// File: rtl/tx_bps_module.sv
// Baud timer: counts 0..BPS_CNT-1 while enabled and flags the last cycle of each bit.
// The tick is registered one cycle early so it lines up with count == BPS_CNT-1.
module tx_bps_module #(
  parameter int unsigned BPS_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en_i,
  output logic bit_end_o
);

  localparam int unsigned CNT_W = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(BPS_CNT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!cnt_en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      tick_q <= (cnt_q == PRE);
    end
  end

  assign bit_end_o = tick_q;

endmodule

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter with registered line, busy and done outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_module
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en_sig,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_pin_out,
  output logic                 tx_busy_sig,
  output logic                 tx_done_sig
);

  localparam int unsigned BPS_CNT = CLK_FREQ / BAUD_RATE;

  generate
    if (BPS_CNT < 2) begin : g_bps_check
      $error("uart_tx_module: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   pin_q, pin_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bps_en_c;
  logic                   bit_end_c;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  assign bps_en_c = (state_q != IDLE) && (state_q != DONE);

  tx_bps_module #(
    .BPS_CNT (BPS_CNT)
  ) u_bps (
    .clk       (clk),
    .rst       (rst),
    .cnt_en_i  (bps_en_c),
    .bit_end_o (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      pin_q     <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      pin_q     <= pin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next state; the line level is computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pin_d     = pin_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        pin_d = IDLE_LEVEL;
        if (tx_en_sig) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_idx_d = '0;
          pin_d     = START_BIT;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          pin_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            pin_d   = parity_q;
`else
            state_d = STOP;
            pin_d   = STOP_BIT;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shift_d   = shift_q >> 1;
            pin_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          state_d = STOP;
          pin_d   = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          state_d = DONE;
          pin_d   = IDLE_LEVEL;
        end
      end
      DONE: begin
        state_d = IDLE;
        pin_d   = IDLE_LEVEL;
      end
      default: begin
        state_d = IDLE;
        pin_d   = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign tx_pin_out  = pin_q;
  assign tx_busy_sig = busy_q;
  assign tx_done_sig = done_q;

endmodule
